mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer for the 4:1 2-bit data selector: shares one output channel among
//  4 requesters. Picks a winner, drives the mux select, forwards the winner's data over a
//  valid/ready handshake and holds the grant for a bounded burst. Sits between producers and the sink.
// PARAMETERS
//  DW          2   data width of each requester lane and of data_o
//  BURST_LEN   4   max handshake beats per grant (>=1)
//  TIMEOUT_CYC 8   consecutive stall cycles before forced release (ARB_TIMEOUT_EN only, >=1)
// PORTS
//  clk_i      in   1    single clock, all state on rising edge
//  rst_ni     in   1    reset, asynchronous assert, active-low
//  req_i      in   4    per-requester request, bit k = requester k
//  data0_i    in   DW   requester 0 data (data1_i..data3_i identical for 1..3)
//  ready_i    in   1    sink ready
//  valid_o    out  1    data_o valid toward sink
//  data_o     out  DW   selected requester data, 0 when valid_o=0
//  sel_o      out  2    registered select (direction code 0..3)
//  gnt_o      out  4    one-hot grant, 0 when idle
//  busy_o     out  1    1 while in GRANT
//  timeout_o  out  1    1-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, ptr=0, sel_o=0, gnt_o=0, valid_o=0, data_o=0, busy_o=0,
//   timeout_o=0, beat_cnt=0, stall_cnt=0. Outputs hold until the first edge after rst_ni rises.
//  FSM IDLE: if |req_i, winner = first set bit scanning ptr, ptr+1.. mod 4; register sel_o/gnt_o,
//   go GRANT. Latency: req seen at edge n -> gnt_o/valid_o high after edge n.
//  FSM GRANT: valid_o = req_i[sel_o] (comb. from registered sel_o); data_o = data<sel_o>_i.
//   Beat = valid_o && ready_i; beat_cnt increments per beat.
//   Release when (a) beat occurs with beat_cnt==BURST_LEN-1, or (b) req_i[sel_o]=0 at an edge.
//   On release: ptr = sel_o+1 mod 4 (3 wraps to 0), gnt_o=0, beat_cnt=0, state=IDLE.
//   Exactly one idle bubble cycle between consecutive grants; sel_o keeps last value in IDLE.
//  No preemption: new requests during GRANT wait; a lone requester is re-granted after the bubble.
//  Backpressure: while valid_o && !ready_i, data_o and sel_o stay stable; no beat counted.
//  Simultaneous req drop and beat on the same edge: beat counts, grant released.
//  beat_cnt width $clog2(BURST_LEN+1); no overflow since release occurs at BURST_LEN.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: stall_cnt counts consecutive valid_o && !ready_i cycles in GRANT,
//   clears on any beat or release; reaching TIMEOUT_CYC forces release (ptr advance as normal)
//   and pulses timeout_o for 1 cycle.
//  Undefined: no stall counter, grant held indefinitely under backpressure, timeout_o tied 0.
// STRUCTURE
//  Package mux4_arb_pkg: state enum (ARB_IDLE, ARB_GRANT), NREQ=4, SEL_W=2, rr-rotate function.
//  One sub-module: rr_picker (comb.: req[3:0], ptr[1:0] -> any, winner[1:0]).
//  Top holds the FSM, counters, and output data mux.
// TESTING (DW=2, BURST_LEN=4, TIMEOUT_CYC=8; data0=01 data1=10 data2=11 data3=00)
//  1. req_i=0001 held, ready_i=1 -> gnt_o=0001 after 1 cycle, sel_o=0, data_o=01, 4 beats,
//     1 idle cycle with valid_o=0, then re-grant to 0.
//  2. req_i=1111 held, ready_i=1 -> grant order 0,1,2,3,0, 4 beats each, sel_o 0->1->2->3->0.
//  3. Requester 1 granted, req_i[1] drops after 2 beats -> release, ptr=2, next grant to 2 if requesting.
//  4. ready_i=0 for 10 cycles in GRANT -> valid_o=1, data_o stable, beat_cnt unchanged; with
//     ARB_TIMEOUT_EN timeout_o pulses on the 8th stall cycle and gnt_o clears; without, grant held.
//  5. rst_ni low mid-burst between edges -> all outputs 0 immediately; after release, req_i=1111 -> grant 0.
//  6. Only req 3 served, then req_i=0001 -> ptr wraps 3->0, grant 0 after the bubble.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
// Optional feature macro used by the arbiter: ARB_TIMEOUT_EN.
package mux4_arb_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    // Rotate the request vector so that bit 0 of the result is requester 'amt'.
    function automatic logic [NREQ-1:0] rr_rotate(input logic [NREQ-1:0] v,
                                                  input logic [SEL_W-1:0] amt);
        logic [NREQ-1:0]  r;
        logic [SEL_W-1:0] idx;
        r = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx  = i[SEL_W-1:0] + amt;
            r[i] = v[idx];
        end
        return r;
    endfunction

    // One-hot decode of a select code.
    function automatic logic [NREQ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner search: first requester at or after ptr.
module rr_picker
    import mux4_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic             any_o,
    output logic [SEL_W-1:0] winner_o
);

    logic [NREQ-1:0]  rot;
    logic [SEL_W-1:0] off;
    logic             found;

    // Find the lowest set bit of the rotated vector and map it back to a requester index.
    always_comb begin
        any_o = |req_i;
        rot   = rr_rotate(req_i, ptr_i);
        off   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                off   = i[SEL_W-1:0];
                found = 1'b1;
            end
        end
        winner_o = ptr_i + off;
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one DW-bit valid/ready channel among 4 requesters.
// Grants are held for at most BURST_LEN beats, with one idle bubble between grants.
// Optional macro ARB_TIMEOUT_EN: force release after TIMEOUT_CYC consecutive stall cycles.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned DW          = 2,
    parameter int unsigned BURST_LEN   = 4,
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NREQ-1:0]  req_i,
    input  logic [DW-1:0]    data0_i,
    input  logic [DW-1:0]    data1_i,
    input  logic [DW-1:0]    data2_i,
    input  logic [DW-1:0]    data3_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [DW-1:0]    data_o,
    output logic [SEL_W-1:0] sel_o,
    output logic [NREQ-1:0]  gnt_o,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int unsigned BCW = $clog2(BURST_LEN + 1);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST_LEN - 1);

    arb_state_e       state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] sel_q;
    logic [NREQ-1:0]  gnt_q;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_winner;
    logic             in_grant;
    logic             owner_req;
    logic             beat;
    logic             last_beat;
    logic             force_rel;
    logic             release_grant;

    rr_picker u_picker (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .any_o    (pick_any),
        .winner_o (pick_winner)
    );

    // Handshake qualification and release decision for the current owner.
    always_comb begin
        in_grant      = (state_q == ARB_GRANT);
        owner_req     = req_i[sel_q];
        valid_o       = in_grant && owner_req;
        beat          = valid_o && ready_i;
        last_beat     = beat && (beat_cnt_q == BEAT_LAST);
        release_grant = in_grant && (last_beat || !owner_req || force_rel);
    end

    // Beat counter next state: cleared on release, advanced on each accepted beat.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (release_grant) begin
            beat_cnt_d = '0;
        end else if (beat) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    // Beat counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TCW-1:0] STALL_LAST = TCW'(TIMEOUT_CYC - 1);

    logic           stall;
    logic [TCW-1:0] stall_cnt_q, stall_cnt_d;
    logic           timeout_q;

    // Stall detection and forced release on the last tolerated stall cycle.
    always_comb begin
        stall       = valid_o && !ready_i;
        force_rel   = stall && (stall_cnt_q == STALL_LAST);
        stall_cnt_d = stall_cnt_q;
        if (release_grant || !stall) begin
            stall_cnt_d = '0;
        end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Consecutive stall counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout_o = 1'b0;

    // TIMEOUT_CYC stays on the interface so both builds instantiate identically.
    if (TIMEOUT_CYC == 0) begin : g_timeout_cfg_unused
    end
`endif

    // Arbitration FSM: pick in IDLE, hold in GRANT, advance pointer past the owner on release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        sel_q   <= pick_winner;
                        gnt_q   <= sel_onehot(pick_winner);
                        state_q <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (release_grant) begin
                        ptr_q     <= sel_q + 1'b1;
                        gnt_q     <= '0;
                        state_q   <= ARB_IDLE;
`ifdef ARB_TIMEOUT_EN
                        timeout_q <= force_rel;
`endif
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    // Output data mux driven from the registered select; zero whenever not valid.
    always_comb begin
        data_o = '0;
        if (valid_o) begin
            case (sel_q)
                2'd0:    data_o = data0_i;
                2'd1:    data_o = data1_i;
                2'd2:    data_o = data2_i;
                default: data_o = data3_i;
            endcase
        end
    end

    assign sel_o  = sel_q;
    assign gnt_o  = gnt_q;
    assign busy_o = in_grant;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter (DW=2, BURST_LEN=4, TIMEOUT_CYC=8).
// Honours ARB_TIMEOUT_EN when defined for the build.
module tb_mux4_rr_arbiter;

    localparam int DW    = 2;
    localparam int BURST = 4;
    localparam int TO    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    req = '0;
    logic          ready = 1'b0;
    logic [DW-1:0] d0 = 2'b01, d1 = 2'b10, d2 = 2'b11, d3 = 2'b00;
    logic          valid;
    logic [DW-1:0] data;
    logic [1:0]    sel;
    logic [3:0]    gnt;
    logic          busy;
    logic          tmo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(
        .DW          (DW),
        .BURST_LEN   (BURST),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .data0_i   (d0),
        .data1_i   (d1),
        .data2_i   (d2),
        .data3_i   (d3),
        .ready_i   (ready),
        .valid_o   (valid),
        .data_o    (data),
        .sel_o     (sel),
        .gnt_o     (gnt),
        .busy_o    (busy),
        .timeout_o (tmo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the channel, how many beats it has used, where the search starts.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_beats = 0;
    int m_stall = 0;
    bit m_to    = 1'b0;
    bit m_v, m_rel;
    int m_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_sel = 0; m_beats = 0; m_stall = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                m_w = -1;
                for (int i = 0; i < 4; i++)
                    if (m_w < 0 && req[(m_ptr + i) % 4]) m_w = (m_ptr + i) % 4;
                if (m_w >= 0) begin
                    m_owner = m_w; m_sel = m_w; m_beats = 0; m_stall = 0;
                end
            end else begin
                m_v   = req[m_owner];
                m_rel = !m_v;
                if (m_v && ready) begin
                    m_beats++;
                    m_stall = 0;
                    if (m_beats == BURST) m_rel = 1'b1;
                end else if (m_v) begin
                    m_stall++;
`ifdef ARB_TIMEOUT_EN
                    if (m_stall == TO) begin
                        m_rel = 1'b1;
                        m_to  = 1'b1;
                    end
`endif
                end
                if (m_rel) begin
                    m_ptr = (m_owner + 1) % 4; m_owner = -1; m_beats = 0; m_stall = 0;
                end
            end
        end
    end

    function automatic logic [1:0] lane(input int k);
        case (k)
            0:       return d0;
            1:       return d1;
            2:       return d2;
            default: return d3;
        endcase
    endfunction

    // Compare every cycle, 3 time units after the rising edge.
    always begin
        logic       ev;
        logic [3:0] eg;
        logic [1:0] ed;
        @(posedge clk);
        #3;
        ev = (m_owner >= 0) ? req[m_owner] : 1'b0;
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        ed = ev ? lane(m_owner) : 2'b00;
        chk("mdl_valid", 32'(valid), 32'(ev));
        chk("mdl_data",  32'(data),  32'(ed));
        chk("mdl_sel",   32'(sel),   32'(m_sel));
        chk("mdl_gnt",   32'(gnt),   32'(eg));
        chk("mdl_busy",  32'(busy),  32'(m_owner >= 0));
        chk("mdl_tmo",   32'(tmo),   32'(m_to));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_v[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        int order[$];
        logic [3:0] prev;
        int n;

        // Reset state
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);

        // 1. Lone requester 0: 4 beats, one bubble, re-grant
        do_reset();
        req = 4'b0001; ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("t1_gnt", 32'(gnt), 32'h1);
                chk("t1_sel", 32'(sel), 32'h0);
                chk("t1_data", 32'(data), 32'h1);
            end
            chk("t1_valid_seq", 32'(valid), 32'(exp_v[k]));
        end

        // 2. All requesting: grant order 0,1,2,3,0
        do_reset();
        req = 4'b1111; ready = 1'b1;
        prev = '0;
        repeat (22) begin
            @(negedge clk);
            if (gnt != 4'b0000 && prev == 4'b0000) order.push_back(int'(sel));
            prev = gnt;
        end
        chk("t2_ngrants", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("t2_order", (order.size() > i) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(exp_ord[i]));

        // 3. Requester 1 drops after 2 beats; pointer moves to 2
        do_reset();
        req = 4'b0010; ready = 1'b1;
        @(negedge clk);
        chk("t3_gnt1", 32'(gnt), 32'h2);
        req = 4'b0110;
        repeat (2) @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        chk("t3_released", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("t3_gnt2", 32'(gnt), 32'h4);
        chk("t3_sel2", 32'(sel), 32'h2);
        chk("t3_data2", 32'(data), 32'h3);

        // 4. Backpressure for 10 cycles, then 4 beats remain
        do_reset();
        req = 4'b0001; ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
`ifdef ARB_TIMEOUT_EN
            chk("t4_gnt", 32'(gnt), (k == 9) ? 32'h0 : 32'h1);
            chk("t4_tmo", 32'(tmo), (k == 9) ? 32'h1 : 32'h0);
`else
            chk("t4_gnt", 32'(gnt), 32'h1);
            chk("t4_valid", 32'(valid), 32'h1);
            chk("t4_data", 32'(data), 32'h1);
`endif
        end
        ready = 1'b1;
        n = 0;
        repeat (5) begin
            if (valid) n++;
            @(negedge clk);
        end
        chk("t4_beats_after_stall", 32'(n), 32'd4);

        // 5. Asynchronous reset mid-burst, then grant restarts at 0
        do_reset();
        req = 4'b1111; ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("t5_pre_sel", 32'(sel), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_gnt", 32'(gnt), 32'h0);
        chk("t5_valid", 32'(valid), 32'h0);
        chk("t5_data", 32'(data), 32'h0);
        chk("t5_sel", 32'(sel), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_tmo", 32'(tmo), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_regrant", 32'(gnt), 32'h1);

        // 6. Requester 3 served, pointer wraps to 0
        do_reset();
        req = 4'b1000; ready = 1'b1;
        @(negedge clk);
        chk("t6_gnt3", 32'(gnt), 32'h8);
        chk("t6_sel3", 32'(sel), 32'h3);
        repeat (4) @(negedge clk);
        chk("t6_bubble", 32'(gnt), 32'h0);
        chk("t6_bubble_sel", 32'(sel), 32'h3);
        req = 4'b1001;
        @(negedge clk);
        chk("t6_wrap_gnt", 32'(gnt), 32'h1);
        chk("t6_wrap_sel", 32'(sel), 32'h0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
